fib_sequencer: RTL and testbench

Sequencer FSM for the lab register-file/ALU datapath. After a `start` request it fills r0..r(NUM_REGS-1) with the Fibonacci sequence. It drives the datapath control fields each cycle: write-enable one-hot, A/B read selects, ALU opcode and immediate. It sits between the board-level demo wrapper (which supplies `start`, a step strobe and the ALU flags) and the register file/ALU pair. Its status outputs feed the hex/LED display logic.

---
 rtl/fib_sequencer.sv | 155 +++++++++++++++
 tb/tb_fib_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fib_sequencer
//  Description : Control sequencer for the register-file/ALU lab datapath.
//                After a start request it fills r0..r(NUM_REGS-1) with the
//                Fibonacci sequence by steering write enables, operand
//                selects, ALU opcode and immediate each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fib_sequencer #(
    parameter int          NUM_REGS  = 16,
    parameter int          DATA_W    = 16,
    parameter logic [3:0]  OP_ADD    = 4'b0101,
    parameter logic [3:0]  OP_MOV    = 4'b1101,
    parameter int          CARRY_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step_en,
    input  logic [4:0]        flags,
    output logic [15:0]       reg_en,
    output logic [3:0]        ra_sel,
    output logic [3:0]        rb_sel,
    output logic              imm_sel,
    output logic [DATA_W-1:0] imm,
    output logic [3:0]        alu_op,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [3:0]        cur_reg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT0 = 3'd1,
        S_INIT1 = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Index of the last register to fill and the first register computed by the ALU.
    localparam logic [3:0]  c_K_LAST   = 4'(NUM_REGS - 1);
    localparam logic [3:0]  c_K_FIRST  = 4'd2;
    // Write-enable bits that correspond to existing registers.
    localparam logic [15:0] c_REG_MASK = 16'((33'd1 << NUM_REGS) - 33'd1);

    state_t      r_state;
    logic [3:0]  r_k;
    logic        r_ovf;
    logic [15:0] w_onehot;
    logic        w_unused_flags;

    // Only the carry flag steers the sequence; the other flags are don't-care.
    assign w_unused_flags = ^flags;

    // Sequencer state, register index and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= c_K_FIRST;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_INIT0;
                        r_k     <= c_K_FIRST;
                        r_ovf   <= 1'b0;
                    end
                end
                S_INIT0: begin
                    if (step_en) begin
                        r_state <= S_INIT1;
                    end
                end
                S_INIT1: begin
                    if (step_en) begin
                        r_state <= S_RUN;
                        r_k     <= c_K_FIRST;
                    end
                end
                S_RUN: begin
                    if (step_en) begin
                        // The write of rk happens on this same edge regardless.
                        if (flags[CARRY_BIT]) begin
                            r_ovf   <= 1'b1;
                            r_state <= S_DONE;
                        end else if (r_k == c_K_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_k <= r_k + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_onehot = 16'd1 << r_k;

    // Moore decode of the datapath control fields from state and index.
    always_comb begin
        reg_en  = 16'd0;
        ra_sel  = 4'd0;
        rb_sel  = 4'd0;
        imm_sel = 1'b0;
        imm     = '0;
        alu_op  = OP_MOV;
        busy    = 1'b0;
        done    = 1'b0;
        cur_reg = 4'd0;
        case (r_state)
            S_INIT0: begin
                reg_en  = 16'd1;
                imm_sel = 1'b1;
                busy    = 1'b1;
            end
            S_INIT1: begin
                reg_en  = 16'd2;
                imm_sel = 1'b1;
                imm     = DATA_W'(1);
                busy    = 1'b1;
                cur_reg = 4'd1;
            end
            S_RUN: begin
                reg_en  = w_onehot;
                ra_sel  = r_k - 4'd2;
                rb_sel  = r_k - 4'd1;
                alu_op  = OP_ADD;
                busy    = 1'b1;
                cur_reg = r_k;
            end
            S_DONE: begin
                done    = 1'b1;
                cur_reg = r_k;
            end
            default: begin
                reg_en = 16'd0;
            end
        endcase
        // A stalled step must never write; unused register slots never write.
        reg_en = reg_en & c_REG_MASK & {16{step_en}};
    end

    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fib_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fib_sequencer
//  Description : Self-checking bench for fib_sequencer with a behavioural
//                register file / ALU and a scoreboard of expected writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_sequencer;

    localparam logic [3:0] c_OP_ADD = 4'b0101;
    localparam logic [15:0] c_SENT  = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst, start, step_en;
    logic [4:0]  flags;
    logic [15:0] reg_en;
    logic [3:0]  ra_sel, rb_sel, alu_op, cur_reg;
    logic        imm_sel, busy, done, ovf;
    logic [15:0] imm;

    logic        force5;
    logic        preload;
    logic [15:0] rf [16];
    logic [15:0] fib_tab [16];
    logic [15:0] w_a, w_b, w_res;
    logic [16:0] w_sum;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] data;
    } wr_t;
    wr_t sb[$];

    int checks = 0;
    int errors = 0;

    fib_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .step_en (step_en),
        .flags   (flags),
        .reg_en  (reg_en),
        .ra_sel  (ra_sel),
        .rb_sel  (rb_sel),
        .imm_sel (imm_sel),
        .imm     (imm),
        .alu_op  (alu_op),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .cur_reg (cur_reg)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; the carry can be forced while r5 is being computed.
    assign w_a   = rf[ra_sel];
    assign w_b   = imm_sel ? imm : rf[rb_sel];
    assign w_sum = {1'b0, w_a} + {1'b0, w_b};
    assign w_res = (alu_op == c_OP_ADD) ? w_sum[15:0] : w_b;
    assign flags = {((alu_op == c_OP_ADD) && w_sum[16]) || (force5 && cur_reg == 4'd5), 4'b0000};

    // Behavioural register file.
    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (preload)
                rf[i] <= c_SENT;
            else if (reg_en[i])
                rf[i] <= w_res;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every write the sequencer issues must match the next expected one.
    always @(negedge clk) begin
        if (!step_en)
            check("stall_reg_en", {16'd0, reg_en}, 32'd0);
        if (reg_en != 16'd0 && !preload) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {16'd0, reg_en}, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_idx", {16'd0, reg_en}, {16'd0, 16'd1 << e.idx});
                check("wr_data", {16'd0, w_res}, {16'd0, e.data});
            end
        end
    end

    task automatic push_fib(input int n);
        for (int i = 0; i < n; i++)
            sb.push_back({4'(i), fib_tab[i]});
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_preload();
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
    endtask

    // Runs from INIT0 until done is seen; n is the edge count from the start edge.
    task automatic run_to_done(input bit stall, input bit pulse9, output int n);
        n = 0;
        while (n < 100) begin
            if (stall)
                step_en = (n % 2 == 0);
            start = pulse9 && busy && (cur_reg == 4'd9);
            @(posedge clk); #1;
            n++;
            if (done)
                break;
        end
        start   = 1'b0;
        step_en = 1'b1;
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        fib_tab[0] = 16'd0;
        fib_tab[1] = 16'd1;
        for (int i = 2; i < 16; i++)
            fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];

        rst = 1'b1; start = 1'b0; step_en = 1'b0; force5 = 1'b0; preload = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        check("rst_reg_en", {16'd0, reg_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_cur", {28'd0, cur_reg}, 32'd0);
        check("rst_op", {28'd0, alu_op}, 32'hD);
        rst = 1'b0;
        step_en = 1'b1;

        // Full run, no stalls.
        push_fib(16);
        do_start();
        check("init0_busy", {31'd0, busy}, 32'd1);
        check("init0_imm_sel", {31'd0, imm_sel}, 32'd1);
        run_to_done(1'b0, 1'b0, n);
        check("full_done_edge", n, 32'd16);
        check("full_ovf", {31'd0, ovf}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("done_pulse", {31'd0, done}, 32'd0);
        for (int i = 0; i < 16; i++)
            check("full_rf", {16'd0, rf[i]}, {16'd0, fib_tab[i]});

        // Alternating stalls.
        do_preload();
        push_fib(16);
        do_start();
        run_to_done(1'b1, 1'b0, n);
        check("stall_done_edge", n, 32'd31);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++)
            check("stall_rf", {16'd0, rf[i]}, {16'd0, fib_tab[i]});

        // Forced carry while writing r5.
        do_preload();
        push_fib(6);
        force5 = 1'b1;
        do_start();
        run_to_done(1'b0, 1'b0, n);
        force5 = 1'b0;
        check("carry_done_edge", n, 32'd6);
        check("carry_ovf", {31'd0, ovf}, 32'd1);
        @(posedge clk); #1;
        check("ovf_sticky", {31'd0, ovf}, 32'd1);
        check("r5_written", {16'd0, rf[5]}, {16'd0, fib_tab[5]});
        for (int i = 6; i < 16; i++)
            check("carry_untouched", {16'd0, rf[i]}, {16'd0, c_SENT});

        // Start during RUN is ignored; new start clears ovf.
        push_fib(16);
        do_start();
        check("ovf_cleared", {31'd0, ovf}, 32'd0);
        run_to_done(1'b0, 1'b1, n);
        check("ign_done_edge", n, 32'd16);
        @(posedge clk); #1;
        check("no_queued_start", {31'd0, busy}, 32'd0);

        // Reset mid-sequence at k=7.
        do_preload();
        push_fib(7);
        do_start();
        n = 0;
        while (n < 50 && !(busy && cur_reg == 4'd7)) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_k7", {31'd0, busy && cur_reg == 4'd7}, 32'd1);
        rst = 1'b1;
        step_en = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_reg_en", {16'd0, reg_en}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step_en = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 7; i++)
            check("mid_rst_rf", {16'd0, rf[i]}, {16'd0, fib_tab[i]});
        check("r7_untouched", {16'd0, rf[7]}, {16'd0, c_SENT});

        // rst and start together.
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        check("rst_start_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("rst_start_idle", {31'd0, busy}, 32'd0);

        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
